// File: rtl/cipher_job_arbiter.sv
// Two-requester round-robin front end for a shared 128-bit block-cipher core.
// Streams key/text as eight 32-bit writes, collects four result reads, and aborts on a stall timeout.
module cipher_job_arbiter #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [127:0] req_text0,
   input  logic [127:0] req_key0,
   input  logic [127:0] req_text1,
   input  logic [127:0] req_key1,
   output logic         rsp_valid,
   output logic         rsp_id,
   output logic         rsp_err,
   output logic [127:0] rsp_data,
   output logic         busy,
   output logic         core_address,
   output logic         core_write,
   output logic [31:0]  core_writedata,
   output logic         core_read,
   input  logic [31:0]  core_readdata,
   input  logic         core_waitrequest
);

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned BLK_W   = 128;
   localparam int unsigned STALL_W = 32;
   localparam int unsigned WR_N    = 8;
   localparam int unsigned RD_N    = 4;
   localparam logic [2:0]  WIDX_LAST = 3'd7;
   localparam logic [1:0]  RIDX_LAST = 2'd3;
   localparam logic [STALL_W-1:0] TIMEOUT_W = STALL_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR   = 3'd1,
      S_RD   = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_e;

   state_e                       state_q, state_d;
   logic                         last_grant_q, last_grant_d;
   logic [2:0]                   widx_q, widx_d;
   logic [1:0]                   ridx_q, ridx_d;
   logic [STALL_W-1:0]           stall_q, stall_d, stall_inc;
   logic [BLK_W-1:0]             text_q, text_d;
   logic [BLK_W-1:0]             key_q, key_d;
   logic [RD_N-1:0][WORD_W-1:0]  result_q, result_d;
   logic [WR_N-1:0][WORD_W-1:0]  job_words;
   logic                         grant_any;
   logic                         grant_id;
   logic                         xfer_ok;
   logic                         timeout_hit;

   // Arbitration, transfer handshake and stall-limit detection.
   always_comb begin
      grant_any   = |req_valid;
      grant_id    = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
      xfer_ok     = ((state_q == S_WR) || (state_q == S_RD)) && !core_waitrequest;
      stall_inc   = (stall_q == '1) ? stall_q : stall_q + STALL_W'(1);
      timeout_hit = (TIMEOUT != 0) && core_waitrequest && (stall_inc == TIMEOUT_W);
      job_words   = {key_q, text_q};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= 1'b1;
         widx_q       <= '0;
         ridx_q       <= '0;
         stall_q      <= '0;
         text_q       <= '0;
         key_q        <= '0;
         result_q     <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         widx_q       <= widx_d;
         ridx_q       <= ridx_d;
         stall_q      <= stall_d;
         text_q       <= text_d;
         key_q        <= key_d;
         result_q     <= result_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      widx_d       = widx_q;
      ridx_d       = ridx_q;
      stall_d      = stall_q;
      text_d       = text_q;
      key_d        = key_q;
      result_d     = result_q;
      unique case (state_q)
         S_IDLE: begin
            if (grant_any) begin
               last_grant_d = grant_id;
               text_d       = grant_id ? req_text1 : req_text0;
               key_d        = grant_id ? req_key1  : req_key0;
               widx_d       = '0;
               ridx_d       = '0;
               stall_d      = '0;
               state_d      = S_WR;
            end
         end
         S_WR: begin
            if (xfer_ok) begin
               stall_d = '0;
               if (widx_q == WIDX_LAST) begin
                  widx_d  = '0;
                  state_d = S_RD;
               end else begin
                  widx_d = widx_q + 3'd1;
               end
            end else begin
               stall_d = stall_inc;
               if (timeout_hit) begin
                  state_d = S_ERR;
               end
            end
         end
         S_RD: begin
            if (xfer_ok) begin
               stall_d          = '0;
               result_d[ridx_q] = core_readdata;
               if (ridx_q == RIDX_LAST) begin
                  ridx_d  = '0;
                  state_d = S_DONE;
               end else begin
                  ridx_d = ridx_q + 2'd1;
               end
            end else begin
               stall_d = stall_inc;
               if (timeout_hit) begin
                  state_d = S_ERR;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // req_ready is a same-cycle grant; held low while reset is asserted.
   always_comb begin
      req_ready      = '0;
      rsp_valid      = 1'b0;
      rsp_id         = 1'b0;
      rsp_err        = 1'b0;
      rsp_data       = '0;
      busy           = (state_q != S_IDLE);
      core_address   = 1'b0;
      core_write     = 1'b0;
      core_writedata = '0;
      core_read      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (grant_any && !reset) begin
               req_ready[grant_id] = 1'b1;
            end
         end
         S_WR: begin
            core_write     = 1'b1;
            core_writedata = job_words[widx_q];
         end
         S_RD: begin
            core_read = 1'b1;
         end
         S_DONE: begin
            rsp_valid = 1'b1;
            rsp_id    = last_grant_q;
            rsp_data  = result_q;
         end
         S_ERR: begin
            rsp_valid = 1'b1;
            rsp_err   = 1'b1;
            rsp_id    = last_grant_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cipher_job_arbiter.sv
// Directed bench for cipher_job_arbiter: one instance at the default timeout, one at a short timeout,
// each talking to a small cipher-core model whose result word i is text[i] ^ halfword-swap(key[i]).
module tb_cipher_job_arbiter;

   localparam logic [127:0] TA = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] KA = 128'hFEDCBA9876543210FEDCBA9876543210;
   localparam logic [127:0] TB = 128'h00000000111111112222222233333333;
   localparam logic [127:0] KB = 128'h00000001000000020000000300000004;
   localparam logic [127:0] RES_A = 128'hBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBB;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [1:0][1:0]   rv, rrdy;
   logic [127:0]      t0, k0, t1, k1;
   logic [1:0]        rspv, rspid, rsperr, bsy, caddr, cw, cr, cwr;
   logic [1:0][127:0] rspd;
   logic [1:0][31:0]  cwd, crd;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   cipher_job_arbiter dut0 (
      .clk(clk), .reset(reset),
      .req_valid(rv[0]), .req_ready(rrdy[0]),
      .req_text0(t0), .req_key0(k0), .req_text1(t1), .req_key1(k1),
      .rsp_valid(rspv[0]), .rsp_id(rspid[0]), .rsp_err(rsperr[0]), .rsp_data(rspd[0]),
      .busy(bsy[0]), .core_address(caddr[0]), .core_write(cw[0]), .core_writedata(cwd[0]),
      .core_read(cr[0]), .core_readdata(crd[0]), .core_waitrequest(cwr[0])
   );

   cipher_job_arbiter #(.TIMEOUT(16)) dut1 (
      .clk(clk), .reset(reset),
      .req_valid(rv[1]), .req_ready(rrdy[1]),
      .req_text0(t0), .req_key0(k0), .req_text1(t1), .req_key1(k1),
      .rsp_valid(rspv[1]), .rsp_id(rspid[1]), .rsp_err(rsperr[1]), .rsp_data(rspd[1]),
      .busy(bsy[1]), .core_address(caddr[1]), .core_write(cw[1]), .core_writedata(cwd[1]),
      .core_read(cr[1]), .core_readdata(crd[1]), .core_waitrequest(cwr[1])
   );

   // Core model state and stall configuration, one set per instance.
   int          wcnt[2], rcnt[2], scnt[2], unstable[2];
   int          st_wr_word[2], st_wr_len[2], st_rd_len[2];
   bit          stuck[2];
   logic [31:0] mem[2][8];
   logic [1:0]  prev_stall, prev_w, prev_r;
   logic [1:0][31:0] prev_wd;

   always_comb begin
      logic [1:0] ri;
      for (int i = 0; i < 2; i++) begin
         ri     = rcnt[i][1:0];
         cwr[i] = 1'b0;
         if (cw[i] && wcnt[i] == st_wr_word[i] && scnt[i] < st_wr_len[i]) cwr[i] = 1'b1;
         if (cr[i] && ((rcnt[i] == 0 && scnt[i] < st_rd_len[i]) || stuck[i])) cwr[i] = 1'b1;
         crd[i] = mem[i][{1'b0, ri}] ^ {mem[i][{1'b1, ri}][15:0], mem[i][{1'b1, ri}][31:16]};
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (!bsy[i]) begin
            wcnt[i]       <= 0;
            rcnt[i]       <= 0;
            scnt[i]       <= 0;
            prev_stall[i] <= 1'b0;
         end else begin
            if (prev_stall[i] && (cw[i] !== prev_w[i] || cr[i] !== prev_r[i] ||
                                  (cw[i] && cwd[i] !== prev_wd[i])))
               unstable[i] <= unstable[i] + 1;
            prev_stall[i] <= cwr[i] && (cw[i] || cr[i]);
            prev_w[i]     <= cw[i];
            prev_r[i]     <= cr[i];
            prev_wd[i]    <= cwd[i];
            if (cw[i] && !cwr[i]) begin
               mem[i][wcnt[i][2:0]] <= cwd[i];
               wcnt[i] <= wcnt[i] + 1;
               scnt[i] <= 0;
            end else if (cr[i] && !cwr[i]) begin
               rcnt[i] <= rcnt[i] + 1;
               scnt[i] <= 0;
            end else if (cwr[i]) begin
               scnt[i] <= scnt[i] + 1;
            end
         end
      end
   end

   function automatic logic [127:0] exp_res(input logic [127:0] t, input logic [127:0] k);
      logic [127:0] r;
      for (int i = 0; i < 4; i++)
         r[i*32 +: 32] = t[i*32 +: 32] ^ {k[i*32 +: 16], k[i*32+16 +: 16]};
      return r;
   endfunction

   // Present one job, wait for its grant, then count cycles until rsp_valid (grant cycle = 0).
   task automatic do_job(input int inst, input int r, input logic [127:0] t, input logic [127:0] k,
                         output int lat, output logic [127:0] data, output logic id, output logic err);
      int n;
      @(negedge clk);
      if (r == 0) begin t0 = t; k0 = k; end
      else begin t1 = t; k1 = k; end
      rv[inst][r] = 1'b1;
      n = 0;
      #1;
      while (!rrdy[inst][r] && n < 100) begin @(negedge clk); #1; n++; end
      tests++;
      if (!rrdy[inst][r]) begin
         fails++;
         $display("FAIL grant_wait inst%0d req%0d: req_ready=%b, required grant within 100 cycles", inst, r, rrdy[inst]);
      end
      @(negedge clk);
      rv[inst][r] = 1'b0;
      lat = 1;
      while (!rspv[inst] && lat < 1000) begin @(negedge clk); lat++; end
      data = rspd[inst];
      id   = rspid[inst];
      err  = rsperr[inst];
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      rv[0] = 2'b11;
      #1;
      tests++;
      if ({rrdy[0], rspv[0], rsperr[0], rspid[0], bsy[0], cw[0], cr[0], caddr[0]} !== 9'd0) begin
         fails++;
         $display("FAIL reset_ctrl: rdy=%b v=%b e=%b id=%b busy=%b w=%b r=%b a=%b, required all 0",
                  rrdy[0], rspv[0], rsperr[0], rspid[0], bsy[0], cw[0], cr[0], caddr[0]);
      end
      tests++;
      if (rspd[0] !== 128'd0 || cwd[0] !== 32'd0) begin
         fails++;
         $display("FAIL reset_data: rsp_data=%h writedata=%h, required 0", rspd[0], cwd[0]);
      end
      rv[0] = 2'b00;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      int n, gcyc, prev_cyc, lat;
      logic [1:0] g, exp_g;
      t0 = TA; k0 = KA; t1 = TB; k1 = KB;
      @(negedge clk);
      rv[0] = 2'b11;
      prev_cyc = 0;
      for (int j = 0; j < 4; j++) begin
         n = 0;
         #1;
         while (rrdy[0] == 2'b00 && n < 100) begin @(negedge clk); #1; n++; end
         g = rrdy[0];
         gcyc = cyc;
         exp_g = (j % 2 == 0) ? 2'b01 : 2'b10;
         tests++;
         if (g !== exp_g) begin
            fails++;
            $display("FAIL rr_grant%0d: req_ready=%b, required %b", j, g, exp_g);
         end
         if (j > 0) begin
            tests++;
            if (gcyc - prev_cyc != 14) begin
               fails++;
               $display("FAIL rr_spacing%0d: %0d cycles between grants, required 14", j, gcyc - prev_cyc);
            end
         end
         prev_cyc = gcyc;
         @(negedge clk);
         if (j == 3) rv[0] = 2'b00;
         lat = 1;
         while (!rspv[0] && lat < 1000) begin @(negedge clk); lat++; end
         tests++;
         if (rspv[0] !== 1'b1 || rspid[0] !== 1'(j % 2) ||
             rspd[0] !== ((j % 2 == 0) ? exp_res(TA, KA) : exp_res(TB, KB))) begin
            fails++;
            $display("FAIL rr_rsp%0d: valid=%b id=%b data=%h, required valid=1 id=%0d", j,
                     rspv[0], rspid[0], rspd[0], j % 2);
         end
      end
   endtask

   task automatic test_single();
      int lat;
      logic [127:0] d;
      logic id, err;
      logic [31:0] exp_w[8];
      exp_w = '{32'h89ABCDEF, 32'h01234567, 32'h89ABCDEF, 32'h01234567,
                32'h76543210, 32'hFEDCBA98, 32'h76543210, 32'hFEDCBA98};
      do_job(0, 0, TA, KA, lat, d, id, err);
      tests++;
      if (lat != 13) begin fails++; $display("FAIL single_latency: %0d, required 13", lat); end
      tests++;
      if (id !== 1'b0 || err !== 1'b0) begin
         fails++; $display("FAIL single_id_err: id=%b err=%b, required 0 0", id, err);
      end
      tests++;
      if (d !== RES_A) begin fails++; $display("FAIL single_data: %h, required %h", d, RES_A); end
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (mem[0][i] !== exp_w[i]) begin
            fails++; $display("FAIL single_wword%0d: %h, required %h", i, mem[0][i], exp_w[i]);
         end
      end
      @(negedge clk);
      tests++;
      if (rspv[0] !== 1'b0) begin fails++; $display("FAIL single_pulse: rsp_valid=%b, required 0", rspv[0]); end
   endtask

   task automatic test_stall();
      int lat, u0;
      logic [127:0] d;
      logic id, err;
      st_wr_word[0] = 2; st_wr_len[0] = 3; st_rd_len[0] = 40;
      u0 = unstable[0];
      do_job(0, 1, TB, KB, lat, d, id, err);
      tests++;
      if (lat != 56) begin fails++; $display("FAIL stall_latency: %0d, required 56", lat); end
      tests++;
      if (d !== exp_res(TB, KB) || id !== 1'b1 || err !== 1'b0) begin
         fails++; $display("FAIL stall_rsp: data=%h id=%b err=%b, required %h 1 0", d, id, err, exp_res(TB, KB));
      end
      tests++;
      if (unstable[0] != u0) begin
         fails++; $display("FAIL stall_stable: %0d unstable stall cycles, required 0", unstable[0] - u0);
      end
      st_wr_word[0] = -1; st_wr_len[0] = 0; st_rd_len[0] = 0;
   endtask

   task automatic test_reset_mid_job();
      int n, nrsp, lat;
      @(negedge clk);
      t0 = TA; k0 = KA; t1 = TB; k1 = KB;
      rv[0][0] = 1'b1;
      n = 0;
      #1;
      while (!rrdy[0][0] && n < 100) begin @(negedge clk); #1; n++; end
      @(negedge clk);
      rv[0] = 2'b00;
      n = 0;
      while (!(cw[0] && wcnt[0] == 5) && n < 50) begin @(negedge clk); n++; end
      tests++;
      if (!(cw[0] && wcnt[0] == 5)) begin
         fails++; $display("FAIL rst_reach_w5: write=%b words=%0d, required 1 5", cw[0], wcnt[0]);
      end
      reset = 1'b1;
      #1;
      tests++;
      if ({rspv[0], rsperr[0], rspid[0], bsy[0], cw[0], cr[0]} !== 6'd0 || cwd[0] !== 32'd0) begin
         fails++;
         $display("FAIL rst_mid_outputs: v=%b e=%b id=%b busy=%b w=%b r=%b wd=%h, required all 0",
                  rspv[0], rsperr[0], rspid[0], bsy[0], cw[0], cr[0], cwd[0]);
      end
      @(negedge clk);
      reset = 1'b0;
      nrsp = 0;
      repeat (20) begin @(negedge clk); if (rspv[0]) nrsp++; end
      tests++;
      if (nrsp != 0 || bsy[0] !== 1'b0) begin
         fails++; $display("FAIL rst_no_rsp: responses=%0d busy=%b, required 0 0", nrsp, bsy[0]);
      end
      rv[0] = 2'b11;
      n = 0;
      #1;
      while (rrdy[0] == 2'b00 && n < 100) begin @(negedge clk); #1; n++; end
      tests++;
      if (rrdy[0] !== 2'b01) begin fails++; $display("FAIL rst_first_grant: %b, required 01", rrdy[0]); end
      @(negedge clk);
      rv[0] = 2'b00;
      lat = 1;
      while (!rspv[0] && lat < 1000) begin @(negedge clk); lat++; end
      tests++;
      if (rspid[0] !== 1'b0 || rspd[0] !== exp_res(TA, KA) || lat != 13) begin
         fails++; $display("FAIL rst_rejob: id=%b data=%h lat=%0d, required 0 %h 13", rspid[0], rspd[0], lat, exp_res(TA, KA));
      end
   endtask

   task automatic test_timeout();
      int lat;
      logic [127:0] d;
      logic id, err;
      stuck[1] = 1'b1;
      do_job(1, 0, TA, KA, lat, d, id, err);
      tests++;
      if (lat != 25) begin fails++; $display("FAIL to_latency: %0d, required 25", lat); end
      tests++;
      if (err !== 1'b1 || d !== 128'd0 || id !== 1'b0) begin
         fails++; $display("FAIL to_rsp: err=%b data=%h id=%b, required 1 0 0", err, d, id);
      end
      tests++;
      if (cw[1] !== 1'b0 || cr[1] !== 1'b0) begin
         fails++; $display("FAIL to_core_idle: write=%b read=%b, required 0 0", cw[1], cr[1]);
      end
      stuck[1] = 1'b0;
      do_job(1, 1, TB, KB, lat, d, id, err);
      tests++;
      if (lat != 13 || err !== 1'b0 || id !== 1'b1 || d !== exp_res(TB, KB)) begin
         fails++; $display("FAIL to_recover: lat=%0d err=%b id=%b data=%h, required 13 0 1 %h", lat, err, id, d, exp_res(TB, KB));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      rv = '0;
      t0 = '0; k0 = '0; t1 = '0; k1 = '0;
      for (int i = 0; i < 2; i++) begin
         st_wr_word[i] = -1; st_wr_len[i] = 0; st_rd_len[i] = 0; stuck[i] = 1'b0; unstable[i] = 0;
      end
      test_reset();
      test_round_robin();
      test_single();
      test_stall();
      test_reset_mid_job();
      test_timeout();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
